// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the serializer / deserializer pair:
// FSM state constants and the counter-width helper.
package piso_serializer_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Counter width for a word of n bits; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Up-counter from 0 to MAX with synchronous clear; shared with the receiver.
module bit_counter #(
  parameter int W   = 3,
  parameter int MAX = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         at_max
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + 1'b1;
    end
  end

  assign at_max = (count == MAX_V);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: valid/ready word load, one bit per
// shift_en cycle, ser_last marks the final bit of each word.
//
// state    | meaning
// ST_IDLE  | no word held, ready for a load
// ST_SHIFT | shreg holds the word being sent, cnt = bits already sent
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_valid,
  input  logic [N-1:0] load_data,
  output logic         load_ready,
  input  logic         shift_en,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         ser_last
);

  localparam int CNT_W = cnt_width(N);

  logic [0:0]       state;
  logic [N-1:0]     shreg;
  logic [CNT_W-1:0] cnt;
  logic             at_max;
  logic             shifting;
  logic             last_taken;
  logic             accept;
  logic             cnt_clear;
  logic             cnt_inc;
  logic [N-1:0]     shreg_next;

  assign shifting   = (state == ST_SHIFT);
  assign last_taken = shifting && shift_en && at_max;
  // shift_en feeds load_ready combinationally so the next word can be
  // accepted on the same edge the last bit is consumed (no gap cycle).
  assign load_ready = !shifting || last_taken;
  assign accept     = load_valid && load_ready;

  assign cnt_clear = accept || last_taken;
  assign cnt_inc   = shifting && shift_en && !at_max;

  assign shreg_next = MSB_FIRST ? {shreg[N-2:0], 1'b0} : {1'b0, shreg[N-1:1]};

  bit_counter #(
    .W   (CNT_W),
    .MAX (N - 1)
  ) u_bit_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .inc    (cnt_inc),
    .count  (cnt),
    .at_max (at_max)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      shreg <= '0;
    end else if (accept) begin
      state <= ST_SHIFT;
      shreg <= load_data;
    end else if (last_taken) begin
      state <= ST_IDLE;
      shreg <= '0;
    end else if (cnt_inc) begin
      shreg <= shreg_next;
    end
  end

  assign ser_valid = shifting;
  assign ser_last  = shifting && at_max;
  assign ser_out   = shifting && (MSB_FIRST ? shreg[N-1] : shreg[0]);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three instances (N=8 MSB-first, N=8 LSB-first,
// N=5 MSB-first) checked every cycle against a word/bit-index model.
module tb_piso_serializer;

  localparam int NL = 3;
  localparam int LN[NL] = '{8, 8, 5};
  localparam bit LM[NL] = '{1'b1, 1'b0, 1'b1};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       lv [NL];
  logic [7:0] ld [NL];
  logic       se [NL];
  logic       lr [NL];
  logic       so [NL];
  logic       sv [NL];
  logic       sl [NL];

  int total = 0;
  int bad   = 0;

  // model: active word, its value, and how many bits have been sent
  bit       m_act  [NL];
  bit [7:0] m_word [NL];
  int       m_sent [NL];

  always #5 clk = ~clk;

  piso_serializer #(.N(8), .MSB_FIRST(1'b1)) dut0 (
    .clk(clk), .reset(reset), .load_valid(lv[0]), .load_data(ld[0]),
    .load_ready(lr[0]), .shift_en(se[0]), .ser_out(so[0]),
    .ser_valid(sv[0]), .ser_last(sl[0]));

  piso_serializer #(.N(8), .MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .reset(reset), .load_valid(lv[1]), .load_data(ld[1]),
    .load_ready(lr[1]), .shift_en(se[1]), .ser_out(so[1]),
    .ser_valid(sv[1]), .ser_last(sl[1]));

  piso_serializer #(.N(5), .MSB_FIRST(1'b1)) dut2 (
    .clk(clk), .reset(reset), .load_valid(lv[2]), .load_data(ld[2][4:0]),
    .load_ready(lr[2]), .shift_en(se[2]), .ser_out(so[2]),
    .ser_valid(sv[2]), .ser_last(sl[2]));

  task automatic check(input string name, input int lane, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s lane%0d t=%0t got=%b want=%b", name, lane, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int lane, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s lane%0d got=%0h want=%0h", name, lane, act, exp);
    end
  endtask

  function automatic bit model_bit(input int i);
    int idx;
    idx = LM[i] ? (LN[i] - 1 - m_sent[i]) : m_sent[i];
    return m_word[i][idx];
  endfunction

  function automatic bit model_ready(input int i);
    return !m_act[i] || (m_sent[i] == LN[i] - 1 && se[i]);
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < NL; i++) begin
      if (reset) begin
        m_act[i]  = 1'b0;
        m_word[i] = '0;
        m_sent[i] = 0;
      end else begin
        if (lv[i] && model_ready(i)) begin
          m_act[i]  = 1'b1;
          m_word[i] = ld[i] & 8'((1 << LN[i]) - 1);
          m_sent[i] = 0;
        end else if (m_act[i] && se[i]) begin
          if (m_sent[i] == LN[i] - 1) m_act[i] = 1'b0;
          else m_sent[i] = m_sent[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NL; i++) begin
      check("ser_valid", i, sv[i], m_act[i]);
      check("ser_out", i, so[i], m_act[i] ? model_bit(i) : 1'b0);
      check("ser_last", i, sl[i], m_act[i] && (m_sent[i] == LN[i] - 1));
      check("load_ready", i, lr[i], model_ready(i));
    end
  end

  task automatic idle_all();
    for (int i = 0; i < NL; i++) begin
      lv[i] = 1'b0;
      se[i] = 1'b1;
      ld[i] = '0;
    end
    repeat (10) @(posedge clk);
  endtask

  // Load one word on a lane with shift_en held high and capture its bits
  // first-sent-first into cap (shifted in from the right).
  task automatic run_word(input int i, input logic [7:0] d, output logic [15:0] cap,
                          output int lastpos);
    @(posedge clk);
    #1;
    lv[i] = 1'b1;
    ld[i] = d;
    se[i] = 1'b1;
    @(posedge clk);
    #1;
    lv[i] = 1'b0;
    cap = '0;
    lastpos = -1;
    for (int k = 0; k < LN[i]; k++) begin
      @(negedge clk);
      cap = {cap[14:0], so[i]};
      if (sl[i]) lastpos = k;
    end
    @(negedge clk);
    check("idle_after_word", i, sv[i], 1'b0);
  endtask

  logic [15:0] cap;
  int          lastpos;

  initial begin
    for (int i = 0; i < NL; i++) begin
      lv[i] = 1'b0;
      ld[i] = '0;
      se[i] = 1'b0;
    end
    #22;
    for (int i = 0; i < NL; i++) begin
      check("rst_valid", i, sv[i], 1'b0);
      check("rst_ready", i, lr[i], 1'b1);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    idle_all();

    run_word(0, 8'hA5, cap, lastpos);
    check_int("msb_a5_bits", 0, int'(cap[7:0]), 'hA5);
    check_int("msb_a5_last", 0, lastpos, 7);
    run_word(1, 8'hA5, cap, lastpos);
    check_int("lsb_a5_bits", 1, int'(cap[7:0]), 'hA5);
    check_int("lsb_a5_last", 1, lastpos, 7);
    run_word(2, 8'h13, cap, lastpos);
    check_int("n5_bits", 2, int'(cap[4:0]), 'h13);
    check_int("n5_last", 2, lastpos, 4);

    // reset mid-word after three bits of 0xFF
    @(posedge clk);
    #1;
    lv[0] = 1'b1;
    ld[0] = 8'hFF;
    @(posedge clk);
    #1 lv[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_valid", 0, sv[0], 1'b0);
    check("midrst_out", 0, so[0], 1'b0);
    check("midrst_last", 0, sl[0], 1'b0);
    check("midrst_ready", 0, lr[0], 1'b1);
    @(posedge clk);
    #1 reset = 1'b0;
    run_word(0, 8'h81, cap, lastpos);
    check_int("post_rst_bits", 0, int'(cap[7:0]), 'h81);

    // stall: four cycles with shift_en low after bit 2 is consumed
    @(posedge clk);
    #1;
    lv[0] = 1'b1;
    ld[0] = 8'h3C;
    se[0] = 1'b1;
    @(posedge clk);
    #1 lv[0] = 1'b0;
    cap = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      cap = {cap[14:0], so[0]};
      if (k == 2) begin
        @(posedge clk);
        #1 se[0] = 1'b0;
        repeat (4) begin
          @(negedge clk);
          check("stall_out", 0, so[0], 1'b1);
          check("stall_valid", 0, sv[0], 1'b1);
          @(posedge clk);
        end
        #1 se[0] = 1'b1;
      end
    end
    check_int("stall_bits", 0, int'(cap[7:0]), 'h3C);

    // back-to-back: load_valid held across two words
    idle_all();
    @(posedge clk);
    #1;
    lv[0] = 1'b1;
    ld[0] = 8'hF0;
    @(posedge clk);
    #1 ld[0] = 8'h0F;
    cap = '0;
    lastpos = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      cap = {cap[14:0], so[0]};
      check("b2b_valid", 0, sv[0], 1'b1);
      if (sl[0]) lastpos = lastpos + k;
      if (k == 3) check("b2b_ready_mid", 0, lr[0], 1'b0);
      if (k == 7) begin
        check("b2b_ready_last", 0, lr[0], 1'b1);
        @(posedge clk);
        #1 lv[0] = 1'b0;
      end
    end
    check_int("b2b_bits", 0, int'(cap), 'hF00F);
    check_int("b2b_lastpos_sum", 0, lastpos, 7 + 15);

    // randomized traffic on all lanes, model checks every cycle
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NL; i++) begin
        lv[i] = ($urandom_range(0, 99) < 45);
        ld[i] = 8'($urandom);
        se[i] = ($urandom_range(0, 99) < 70);
      end
      if (c == 2000) begin
        #2 reset = 1'b1;
        #3 reset = 1'b0;
      end
    end

    idle_all();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
